sys_ctrl: RTL and testbench
===========================

# sys_ctrl

Single-clock system controller for the Game Boy core. It sequences the power-on core reset and generates the core clock enable, replacing the free-running reset-delay counter and the gated `clk_gb | halt` clock. It also executes single-byte debug commands from `uart_rx`: halt, run, step N core cycles, core reset and status. Every command is acknowledged over a valid/ready byte interface to the UART transmitter.

## Interface
Parameters:
- `DIV_2N`, 6, core enable period = 2^DIV_2N clk cycles
- `RST_WAIT`, 3840, clk cycles in WAIT before core reset
- `RST_LEN`, 255, clk cycles `gb_rst` is held high
- `START_HALTED`, 0, 1 = enter HALT instead of RUN after reset sequence

Ports:
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  reset; synchronous, active-low
- `rx_valid`  in  1  single-cycle strobe, `rx_byte` valid
- `rx_byte`  in  8  received command/argument byte
- `tx_valid`  out  1  ack byte available
- `tx_ready`  in  1  transmitter accepts byte
- `tx_byte`  out  8  ack/status byte
- `gb_rst`  out  1  active-high core reset
- `gb_ce`  out  1  one-cycle core clock enable
- `halted`  out  1  high in HALT state

## Operation
- States:
  - WAIT → RESET after RST_WAIT cycles.
  - RESET → RUN (or HALT if START_HALTED) after RST_LEN cycles.
  - RUN, HALT.
  - STEP_ARG: awaiting count byte.
  - STEP: issuing counted enables.
- Divider counter of DIV_2N bits, free-running from reset. A tick occurs when the counter is all-ones.
- `gb_ce` equals the tick in RESET, RUN and STEP. It is 0 in WAIT, HALT and STEP_ARG.
- `gb_rst` = 1 exactly in RESET.
- Commands are decoded on the `rx_valid` cycle. Codes:
  - `H` 0x48: RUN/STEP → HALT, ACK.
  - `R` 0x52: HALT → RUN, ACK.
  - `S` 0x53: HALT → STEP_ARG, no ack yet.
    - The next `rx_valid` byte n is the argument (any value, not decoded as a command).
    - n=0: ACK, stay in HALT.
    - n>0: ACK, STEP with remaining = n. Each `gb_ce` in STEP decrements remaining. When the last one is issued, go to HALT.
  - `X` 0x58: any state → RESET with counter cleared, ACK.
  - `?` 0x3F: any state except STEP_ARG; replies status {3'b0, ovf, in_step, in_reset, in_wait, halted}.
  - Anything else, or a valid code in a state where it is not listed (e.g. `S` in RUN, `H`/`R`/`S` in WAIT/RESET): NAK 0x15, no state change. ACK = 0x06.
- Ack buffer is one entry deep. If a new ack is produced while `tx_valid`=1 and it is not accepted that cycle, the command still executes, the new ack is dropped, and sticky `ovf` is set. `ovf` is cleared only by reset.

## Timing
- Reset values: `tx_valid`=0, `tx_byte`=0, `gb_rst`=0, `gb_ce`=0, `halted`=0, `ovf`=0, divider=0, state WAIT.
- First `gb_rst`=1 occurs RST_WAIT cycles after `rst_n` deasserts.
- Ack latency: `tx_valid` rises the cycle after `rx_valid`. A byte transfers on any cycle with `tx_valid`&&`tx_ready`. `tx_valid` drops the next cycle unless a new ack is loaded in that same cycle; load-and-accept in one cycle keeps `tx_valid` high with the new byte.
- State changes take effect the cycle after `rx_valid`. `H` in the same cycle as a tick still lets that tick's `gb_ce` out; none follow.
- The divider is never reset by commands, only by `rst_n`. A step's first enable therefore comes at the next tick.
- `rst_n` low mid-step or mid-reset: immediate return to reset values on the next edge.

## Structure
- Package `sys_ctrl_pkg`: command codes (CMD_HALT, CMD_RUN, CMD_STEP, CMD_RESET, CMD_STATUS), ACK/NAK constants, state enum.
- Sub-module `ce_div`: parametrised DIV_2N tick generator with synchronous active-low reset.
- Counters sized with `$clog2` of RST_WAIT/RST_LEN; step counter is 8 bits.

## Test plan
- Release `rst_n` (RST_WAIT=16, RST_LEN=8, DIV_2N=2) → `gb_rst` high on cycles 16..23. `gb_ce` pulses every 4 cycles from the RESET entry, continuing into RUN.
- RUN, send `H` → ACK 0x06 next cycle, `halted`=1, zero `gb_ce` over 100 cycles. Send `R` → ACK, pulses resume.
- HALT, send `S` then 0x05 → one ACK after the argument, exactly 5 `gb_ce` pulses, then `halted`=1. `S` then 0x00 → ACK, 0 pulses.
- Send `S` in RUN, and 0x41 in HALT → NAK 0x15 each, state unchanged. `?` in HALT → 0x01.
- Hold `tx_ready`=0 and send `H` then `R` → only the first ack is presented. `?` after release → bit4 (`ovf`) set. State is RUN.
- `X` during STEP with remaining=200 → ACK, `gb_rst` high RST_LEN cycles, then RUN. Assert `rst_n`=0 mid-RESET → all outputs at reset values next edge.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared constants and state encoding for the Game Boy system controller.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_HALT   = 8'h48;
    localparam logic [7:0] CMD_RUN    = 8'h52;
    localparam logic [7:0] CMD_STEP   = 8'h53;
    localparam logic [7:0] CMD_RESET  = 8'h58;
    localparam logic [7:0] CMD_STATUS = 8'h3F;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_RESET,
        ST_RUN,
        ST_HALT,
        ST_STEP_ARG,
        ST_STEP
    } state_t;

endpackage

// File: rtl/sys_ctrl_ce_div.sv
// Free-running 2^DIV_2N divider; tick is high for one clk when the count is all-ones.
module ce_div #(
    parameter int DIV_2N = 6
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [DIV_2N-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + 1'b1;
    end

    assign tick = &cnt;

endmodule

// File: rtl/sys_ctrl.sv
// Core reset sequencer, core clock-enable gate and single-byte debug command
// executor with a one-entry acknowledge buffer toward the UART transmitter.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DIV_2N       = 6,
    parameter int RST_WAIT     = 3840,
    parameter int RST_LEN      = 255,
    parameter bit START_HALTED = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       gb_rst,
    output logic       gb_ce,
    output logic       halted
);

    localparam int SEQ_MAX = (RST_WAIT > RST_LEN) ? RST_WAIT : RST_LEN;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam logic [SEQ_W-1:0] WAIT_LAST = SEQ_W'(RST_WAIT - 1);
    localparam logic [SEQ_W-1:0] LEN_LAST  = SEQ_W'(RST_LEN - 1);
    localparam state_t POST_RESET = START_HALTED ? ST_HALT : ST_RUN;

    state_t           state, state_nx;
    logic [SEQ_W-1:0] seq_cnt, seq_nx;
    logic [7:0]       step_rem, step_nx;
    logic             tick;
    logic             ovf;
    logic             ack_new;
    logic [7:0]       ack_byte;
    logic [7:0]       status;

    ce_div #(.DIV_2N(DIV_2N)) u_ce_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign gb_ce  = tick && (state == ST_RESET || state == ST_RUN || state == ST_STEP);
    assign gb_rst = (state == ST_RESET);
    assign halted = (state == ST_HALT);
    assign status = {3'b000, ovf, state == ST_STEP, state == ST_RESET,
                     state == ST_WAIT, state == ST_HALT};

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        seq_nx   = '0;
        step_nx  = step_rem;
        ack_new  = 1'b0;
        ack_byte = NAK;

        case (state)
            ST_WAIT:  if (seq_cnt == WAIT_LAST) state_nx = ST_RESET;
                      else                      seq_nx   = seq_cnt + 1'b1;
            ST_RESET: if (seq_cnt == LEN_LAST)  state_nx = POST_RESET;
                      else                      seq_nx   = seq_cnt + 1'b1;
            ST_STEP:  if (gb_ce) begin
                          step_nx = step_rem - 1'b1;
                          if (step_rem == 8'd1) state_nx = ST_HALT;
                      end
            default: ;
        endcase

        // A command overrides the autonomous progression above.
        if (rx_valid) begin
            ack_new = 1'b1;
            if (state == ST_STEP_ARG) begin
                ack_byte = ACK;
                if (rx_byte == 8'd0) state_nx = ST_HALT;
                else begin
                    state_nx = ST_STEP;
                    step_nx  = rx_byte;
                end
            end else begin
                case (rx_byte)
                    CMD_HALT:   if (state == ST_RUN || state == ST_STEP) begin
                                    state_nx = ST_HALT;
                                    ack_byte = ACK;
                                end
                    CMD_RUN:    if (state == ST_HALT) begin
                                    state_nx = ST_RUN;
                                    ack_byte = ACK;
                                end
                    CMD_STEP:   if (state == ST_HALT) begin
                                    state_nx = ST_STEP_ARG;
                                    ack_new  = 1'b0;
                                end
                    CMD_RESET:  begin
                                    state_nx = ST_RESET;
                                    seq_nx   = '0;
                                    ack_byte = ACK;
                                end
                    CMD_STATUS: ack_byte = status;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_WAIT;
            seq_cnt  <= '0;
            step_rem <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nx;
            seq_cnt  <= seq_nx;
            step_rem <= step_nx;
            // The slot is free if empty or being drained this cycle.
            if (ack_new && (!tx_valid || tx_ready)) begin
                tx_valid <= 1'b1;
                tx_byte  <= ack_byte;
            end else begin
                if (ack_new)  ovf      <= 1'b1;
                if (tx_ready) tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: directed scenarios plus random commands,
// compared each cycle against a time-stamp based behavioural model.
module tb_sys_ctrl;

    localparam int DIV     = 2;
    localparam int PERIOD  = 1 << DIV;
    localparam int R_WAIT  = 16;
    localparam int R_LEN   = 8;

    localparam int M_WAIT = 0, M_RESET = 1, M_RUN = 2, M_HALT = 3, M_ARG = 4, M_STEP = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       gb_rst;
    logic       gb_ce;
    logic       halted;

    sys_ctrl #(
        .DIV_2N(DIV), .RST_WAIT(R_WAIT), .RST_LEN(R_LEN), .START_HALTED(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
        .gb_rst(gb_rst), .gb_ce(gb_ce), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: modes are tracked with entry time stamps rather than counters.
    int         edges = 0;
    int         m_er, m_since, m_mode, m_left;
    bit         m_txv, m_ovf;
    logic [7:0] m_txb;

    function automatic bit model_tick();
        return ((edges - m_er - 1) % PERIOD) == PERIOD - 1;
    endfunction

    function automatic bit model_ce();
        return model_tick() && (m_mode == M_RESET || m_mode == M_RUN || m_mode == M_STEP);
    endfunction

    function automatic logic [11:0] model_out();
        return {m_mode == M_RESET, model_ce(), m_mode == M_HALT, m_txv, m_txb};
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [7:0] b, input bit rdy);
        int n, nm;
        bit ce, gen, restart;
        logic [7:0] rep;
        n = edges;
        if (!r) begin
            m_mode = M_WAIT; m_since = n; m_er = n; m_left = 0;
            m_txv = 0; m_txb = 8'h00; m_ovf = 0;
        end else begin
            ce = model_ce();
            nm = m_mode; gen = 0; restart = 0; rep = 8'h15;
            if (m_mode == M_WAIT  && n - m_since == R_WAIT) nm = M_RESET;
            if (m_mode == M_RESET && n - m_since == R_LEN)  nm = M_RUN;
            if (m_mode == M_STEP && ce) begin
                m_left--;
                if (m_left == 0) nm = M_HALT;
            end
            if (v) begin
                gen = 1;
                if (m_mode == M_ARG) begin
                    rep = 8'h06;
                    if (b == 0) nm = M_HALT;
                    else begin nm = M_STEP; m_left = int'(b); end
                end else if (b == 8'h58) begin
                    nm = M_RESET; restart = 1; rep = 8'h06;
                end else if (b == 8'h3F) begin
                    rep = {3'b000, m_ovf, m_mode == M_STEP, m_mode == M_RESET,
                           m_mode == M_WAIT, m_mode == M_HALT};
                end else if (b == 8'h48 && (m_mode == M_RUN || m_mode == M_STEP)) begin
                    nm = M_HALT; rep = 8'h06;
                end else if (b == 8'h52 && m_mode == M_HALT) begin
                    nm = M_RUN; rep = 8'h06;
                end else if (b == 8'h53 && m_mode == M_HALT) begin
                    nm = M_ARG; gen = 0;
                end
            end
            if (gen) begin
                if (!m_txv || rdy) begin m_txv = 1; m_txb = rep; end
                else m_ovf = 1;
            end else if (m_txv && rdy) m_txv = 0;
            if (restart || nm != m_mode) m_since = n;
            m_mode = nm;
        end
        edges++;
    endtask

    int          ce_seen, rst_seen, first_rst;
    logic [7:0]  samp_tx;
    logic [11:0] samp_all;

    // Sample this cycle's outputs, then drive this cycle's inputs.
    task automatic cyc(input bit r, input bit v, input logic [7:0] b, input bit rdy);
        @(negedge clk);
        samp_all = {gb_rst, gb_ce, halted, tx_valid, tx_byte};
        check("cycle", 32'(samp_all), 32'(model_out()));
        samp_tx = tx_byte;
        if (gb_ce) ce_seen++;
        if (gb_rst) begin
            rst_seen++;
            if (first_rst < 0) first_rst = edges - m_er - 1;
        end
        rst_n = r; rx_valid = v; rx_byte = b; tx_ready = rdy;
        model_edge(r, v, b, rdy);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1, 0, 8'h00, 1);
    endtask

    task automatic cmd(input logic [7:0] b);
        cyc(1, 1, b, 1);
        cyc(1, 0, 8'h00, 1);
    endtask

    initial begin
        logic [7:0] picks [8];
        logic [7:0] b;
        picks = '{8'h48, 8'h52, 8'h53, 8'h3F, 8'h48, 8'h52, 8'h00, 8'h58};

        rst_n = 0; rx_valid = 0; rx_byte = 0; tx_ready = 1;
        model_edge(0, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1);

        ce_seen = 0; rst_seen = 0; first_rst = -1;
        idle(40);
        check("rst_first", 32'(first_rst), 32'd16);
        check("rst_len", 32'(rst_seen), 32'(R_LEN));

        cyc(1, 1, 8'h48, 1);
        ce_seen = 0;
        idle(100);
        check("halt_no_ce", 32'(ce_seen), 32'd0);
        check("halt_flag", 32'(halted), 32'd1);

        cyc(1, 1, 8'h52, 1);
        ce_seen = 0;
        idle(20);
        check("run_ce", 32'(ce_seen), 32'd5);

        cmd(8'h48); idle(5);
        cmd(8'h53); idle(3);
        cyc(1, 1, 8'h05, 1);
        ce_seen = 0;
        idle(40);
        check("step5_ce", 32'(ce_seen), 32'd5);
        check("step5_halt", 32'(halted), 32'd1);

        cmd(8'h53);
        cyc(1, 1, 8'h00, 1);
        ce_seen = 0;
        idle(20);
        check("step0_ce", 32'(ce_seen), 32'd0);

        cmd(8'h52);
        cmd(8'h53);
        check("nak_s_run", 32'(samp_tx), 32'h15);
        cmd(8'h48);
        cmd(8'h41);
        check("nak_41", 32'(samp_tx), 32'h15);
        cmd(8'h3F);
        check("status_halt", 32'(samp_tx), 32'h01);

        cmd(8'h52); idle(2);
        cyc(1, 1, 8'h48, 0);
        cyc(1, 0, 8'h00, 0);
        cyc(1, 1, 8'h52, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, 0);
        idle(3);
        cmd(8'h3F);
        check("ovf_status", 32'(samp_tx), 32'h10);
        check("ovf_run", 32'(halted), 32'd0);

        cmd(8'h48);
        cmd(8'h53);
        cmd(8'hC8);
        idle(10);
        rst_seen = 0;
        cmd(8'h58);
        idle(20);
        check("x_rst_len", 32'(rst_seen), 32'(R_LEN));
        check("x_run", 32'({gb_rst, halted}), 32'd0);

        cmd(8'h58); idle(3);
        cyc(0, 0, 8'h00, 1);
        cyc(1, 0, 8'h00, 1);
        check("rst_mid", 32'(samp_all), 32'd0);

        for (int i = 0; i < 800; i++) begin
            b = picks[$urandom_range(0, 7)];
            if (b == 8'h00) b = 8'($urandom);
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) == 0), b,
                ($urandom_range(0, 2) != 0));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
